serial_byte_transmitter: RTL and testbench



---
 rtl/serial_byte_transmitter_if.sv | 25 ++
 rtl/serial_byte_transmitter.sv | 132 +++++++++++++
 tb/tb_serial_byte_transmitter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_transmitter_if.sv
// Handshake bundle between a word producer, the serial transmitter and the bit sink.
// master: the side that supplies words and consumes bits; slave: the transmitter.
interface serial_byte_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parIn;
    logic             inValid;
    logic             inReady;
    logic             serOut;
    logic             serValid;
    logic             serReady;
    logic             abort;
    logic             busy;
    logic             done;

    modport master (
        output parIn, inValid, serReady, abort,
        input  inReady, serOut, serValid, busy, done
    );

    modport slave (
        input  parIn, inValid, serReady, abort,
        output inReady, serOut, serValid, busy, done
    );
endinterface

// File: rtl/serial_byte_transmitter.sv
// Parallel-to-serial transmitter: loads a WIDTH-bit word over valid/ready and
// shifts it out LSB first, one bit per accepted beat, then pulses done.
// Optional feature macro: PARITY_EN appends an even-parity bit after the data.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a word, inReady=1
// S_SHIFT  | data bit on serOut, advances when serReady=1
// S_PARITY | (PARITY_EN only) parity bit on serOut, advances on serReady
// S_DONE   | one-cycle done pulse, returns to S_IDLE
module serial_byte_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_byte_transmitter_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DONE   = 2'd2
    } state_t;
`endif

    state_t             state;
    // Holds the bits still waiting to go out; the bit on serOut has already
    // been moved into the serOut register, so outputs stay registered.
    logic [WIDTH-1:0]   sh_reg;
    logic [CNT_W-1:0]   cnt;
`ifdef PARITY_EN
    logic               parity_q;
`endif

    // Frame sequencing with registered outputs; abort outranks every non-idle transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            sh_reg       <= '0;
            cnt          <= '0;
            bus.inReady  <= 1'b1;
            bus.serOut   <= 1'b0;
            bus.serValid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else if (state != S_IDLE && bus.abort) begin
            state        <= S_IDLE;
            sh_reg       <= '0;
            cnt          <= '0;
            bus.inReady  <= 1'b1;
            bus.serOut   <= 1'b0;
            bus.serValid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.inValid) begin
                        state        <= S_SHIFT;
                        sh_reg       <= bus.parIn >> 1;
                        cnt          <= '0;
                        bus.inReady  <= 1'b0;
                        bus.serOut   <= bus.parIn[0];
                        bus.serValid <= 1'b1;
                        bus.busy     <= 1'b1;
`ifdef PARITY_EN
                        parity_q     <= ^bus.parIn;
`endif
                    end
                end
                S_SHIFT: begin
                    if (bus.serReady) begin
                        sh_reg <= sh_reg >> 1;
                        if (cnt == LAST) begin
                            // Terminal count: clear rather than let cnt wrap.
                            cnt <= '0;
`ifdef PARITY_EN
                            state      <= S_PARITY;
                            bus.serOut <= parity_q;
`else
                            state        <= S_DONE;
                            bus.serOut   <= 1'b0;
                            bus.serValid <= 1'b0;
                            bus.done     <= 1'b1;
`endif
                        end else begin
                            cnt        <= cnt + 1'b1;
                            bus.serOut <= sh_reg[0];
                        end
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (bus.serReady) begin
                        state        <= S_DONE;
                        bus.serOut   <= 1'b0;
                        bus.serValid <= 1'b0;
                        bus.done     <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state       <= S_IDLE;
                    bus.done    <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.inReady <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    bus.inReady  <= 1'b1;
                    bus.serOut   <= 1'b0;
                    bus.serValid <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.done     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_byte_transmitter.sv
// Bench for serial_byte_transmitter: directed frames plus randomized words and
// back-pressure, checked against a bit-queue model of the frame.
module tb_serial_byte_transmitter;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_asserts = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    int   last_load = 0;

    serial_byte_transmitter_if #(.WIDTH(W)) bus ();

    serial_byte_transmitter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_serValid"}, bus.serValid, 1'b0);
        check({tag, "_busy"},     bus.busy,     1'b0);
        check({tag, "_inReady"},  bus.inReady,  1'b1);
        check({tag, "_done"},     bus.done,     1'b0);
    endtask

    // Sends one frame starting at a falling edge and returns at a falling edge.
    // The model is the queue of bits the frame must carry; each accepted beat pops one.
    task automatic run_frame(input logic [W-1:0] w, input int stall_bit, input int stall_len,
                             input bit rand_stall, input int abort_at, input bit abort_on_load,
                             input bit hold_next, input logic [W-1:0] next_w);
        logic       q[$];
        logic [W-1:0] rx;
        int         idx;
        int         stalls;
        int         stalls_left;
        int         budget;
        bit         aborted;
        logic       r;

        check("load_inReady", bus.inReady, 1'b1);
        bus.parIn   = w;
        bus.inValid = 1'b1;
        bus.abort   = abort_on_load;
        @(negedge clk);
        last_load = cyc_cnt;
        bus.abort = 1'b0;
        if (hold_next) begin
            bus.parIn = next_w;
        end else begin
            bus.inValid = 1'b0;
            bus.parIn   = W'($urandom);
        end

        for (int i = 0; i < W; i++) q.push_back(w[i]);
`ifdef PARITY_EN
        q.push_back(^w);
`endif
        rx = '0;
        idx = 0;
        stalls = 0;
        stalls_left = stall_len;
        budget = 400;
        aborted = 1'b0;

        while (q.size() > 0 && budget > 0) begin
            budget--;
            check("bit_serValid", bus.serValid, 1'b1);
            check("bit_serOut",   bus.serOut,   q[0]);
            check("bit_busy",     bus.busy,     1'b1);
            check("bit_inReady",  bus.inReady,  1'b0);
            check("bit_done",     bus.done,     1'b0);
            if (idx == stall_bit && stalls_left > 0) begin
                r = 1'b0;
                stalls_left--;
            end else if (rand_stall) begin
                r = ($urandom_range(0, 3) != 0);
            end else begin
                r = 1'b1;
            end
            bus.serReady = r;
            if (idx == abort_at) begin
                bus.abort = 1'b1;
                aborted = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                break;
            end
            if (!r) stalls++;
            @(negedge clk);
            if (r) begin
                if (idx < W) rx = {q[0], rx[W-1:1]};
                void'(q.pop_front());
                idx++;
            end
        end

        if (aborted) begin
            check_idle("abort");
        end else if (budget == 0) begin
            check("frame_timeout", 32'd0, 32'd1);
        end else begin
            check("loopback_parOut", rx, w);
            check("done_pulse",    bus.done,     1'b1);
            check("done_serValid", bus.serValid, 1'b0);
            check("done_busy",     bus.busy,     1'b1);
            check("done_inReady",  bus.inReady,  1'b0);
            check("done_latency",  cyc_cnt - last_load, NB + stalls);
            bus.serReady = 1'(($urandom));
            @(negedge clk);
            check_idle("after_done");
        end
    endtask

    initial begin
        int l1;
        logic [W-1:0] w;
        bus.parIn    = '0;
        bus.inValid  = 1'b0;
        bus.serReady = 1'b0;
        bus.abort    = 1'b0;

        // reset state
        #12;
        check("rst_serValid", bus.serValid, 1'b0);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_done",     bus.done,     1'b0);
        check("rst_serOut",   bus.serOut,   1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // plain frame, looped-back receiver sees the word
        run_frame(8'hA5, -1, 0, 1'b0, -1, 1'b0, 1'b0, '0);
        // three-cycle stall on bit 2
        run_frame(8'h3C, 2, 3, 1'b0, -1, 1'b0, 1'b0, '0);
        // abort during bit 4, next word still fine
        run_frame(8'hFF, -1, 0, 1'b0, 4, 1'b0, 1'b0, '0);
        run_frame(8'h01, -1, 0, 1'b0, -1, 1'b0, 1'b0, '0);
        // abort beats the last-bit transition
        run_frame(8'h5A, -1, 0, 1'b0, NB - 1, 1'b0, 1'b0, '0);
        // inValid held: back-to-back spacing, parIn change mid-frame ignored
        run_frame(8'h0F, -1, 0, 1'b0, -1, 1'b0, 1'b1, 8'hF0);
        l1 = last_load;
        run_frame(8'hF0, -1, 0, 1'b0, -1, 1'b0, 1'b0, '0);
        check("frame_spacing", last_load - l1, NB + 2);
        // abort in IDLE with a simultaneous load: word still accepted
        run_frame(8'hC3, -1, 0, 1'b0, -1, 1'b1, 1'b0, '0);
`ifdef PARITY_EN
        run_frame(8'h07, -1, 0, 1'b0, -1, 1'b0, 1'b0, '0);
`endif

        // reset mid-frame drops the frame with no done
        bus.parIn   = 8'hA5;
        bus.inValid = 1'b1;
        @(negedge clk);
        bus.inValid  = 1'b0;
        bus.serReady = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_serValid", bus.serValid, 1'b0);
        check("midrst_busy",     bus.busy,     1'b0);
        check("midrst_done",     bus.done,     1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midrst_release");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_no_done", bus.done, 1'b0);
        end

        // randomized words, back-pressure and occasional aborts
        for (int n = 0; n < 25; n++) begin
            w = W'($urandom);
            run_frame(w, -1, 0, 1'b1,
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
                      1'($urandom), 1'b0, '0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_inReady", bus.inReady, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
